rotate_slice_assembler: RTL

//  Sequencer/assembler for the rho (rotate) stage, one slice at a time.

---
 rtl/rotate_slice_assembler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rotate_slice_assembler.sv
// Rho-stage sequencer: walks every lane of every slice through the slice reader,
// assembles the rotated bits and streams each finished slice toward pi.
module rotate_slice_assembler #(
  parameter int unsigned N      = 25,
  parameter int unsigned SLICES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] pout_in,
  output logic         ld_des_fr,
  output logic [6:0]   line_number,
  output logic [4:0]   index,
  output logic         slice_valid,
  input  logic         slice_ready,
  output logic [5:0]   slice_num,
  output logic [N-1:0] slice_data,
  output logic         busy,
  output logic         done
);

  localparam int unsigned LANE_W  = 5;
  localparam int unsigned SLICE_W = 6;
  localparam int unsigned LINE_W  = 7;
  localparam logic [LANE_W-1:0]  LAST_LANE  = LANE_W'(N - 1);
  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(SLICES - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAPT = 3'd2,
    OUT  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [SLICE_W-1:0] z, z_n;
  logic [LANE_W-1:0]  i, i_n;
  logic [N-1:0]       asm_q, asm_n;

  logic               ld_des_fr_n;
  logic [LINE_W-1:0]  line_number_n;
  logic [LANE_W-1:0]  index_n;
  logic               slice_valid_n;
  logic [SLICE_W-1:0] slice_num_n;
  logic [N-1:0]       slice_data_n;
  logic               busy_n;
  logic               done_n;

  // State, counters and registered outputs; reset aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      z           <= '0;
      i           <= '0;
      asm_q       <= '0;
      ld_des_fr   <= 1'b0;
      line_number <= LINE_W'(1);
      index       <= '0;
      slice_valid <= 1'b0;
      slice_num   <= '0;
      slice_data  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      z           <= z_n;
      i           <= i_n;
      asm_q       <= asm_n;
      ld_des_fr   <= ld_des_fr_n;
      line_number <= line_number_n;
      index       <= index_n;
      slice_valid <= slice_valid_n;
      slice_num   <= slice_num_n;
      slice_data  <= slice_data_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  // Next state and counters, then outputs derived from where the FSM is heading.
  always_comb begin
    state_n       = state;
    z_n           = z;
    i_n           = i;
    asm_n         = asm_q;
    line_number_n = line_number;
    index_n       = index;
    slice_num_n   = slice_num;
    slice_data_n  = slice_data;
    ld_des_fr_n   = 1'b0;
    slice_valid_n = 1'b0;
    busy_n        = 1'b0;
    done_n        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          z_n     = '0;
          i_n     = '0;
          asm_n   = '0;
          state_n = REQ;
        end
      end
      REQ: state_n = CAPT;
      CAPT: begin
        asm_n[i] = pout_in[i];
        if (i == LAST_LANE) begin
          state_n = OUT;
        end else begin
          i_n     = i + LANE_W'(1);
          state_n = REQ;
        end
      end
      OUT: begin
        if (slice_valid && slice_ready) begin
          if (z == LAST_SLICE) begin
            state_n = DONE;
          end else begin
            z_n     = z + SLICE_W'(1);
            i_n     = '0;
            asm_n   = '0;
            state_n = REQ;
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (state_n == REQ) begin
      ld_des_fr_n   = 1'b1;
      line_number_n = LINE_W'(z_n) + LINE_W'(1);
      index_n       = i_n;
    end
    // Slice payload is loaded once on entry to OUT and frozen until accepted.
    if (state_n == OUT) begin
      slice_valid_n = 1'b1;
      if (state != OUT) begin
        slice_data_n = asm_n;
        slice_num_n  = z_n;
      end
    end
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

endmodule
